// File: rtl/cpu_types_pkg.sv
// Shared CPU types: load opcodes, load/writeback FSM states and the
// request-legality rule used when a load is accepted.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    LB          = 3'd0,
    LBU         = 3'd1,
    LH          = 3'd2,
    LHU         = 3'd3,
    LW          = 3'd4,
    LWL         = 3'd5,
    LWR         = 3'd6,
    LOP_ILLEGAL = 3'd7
  } load_op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    WRITEBACK = 2'd2,
    ERROR     = 2'd3
  } lwb_state_t;

  // Halfword loads need an even address, LW needs a word-aligned one.
  // LWL/LWR and byte loads accept any alignment.
  function automatic logic bad_request(load_op_t op, logic [1:0] b);
    logic bad;
    bad = 1'b0;
    case (op)
      LH, LHU:     bad = b[0];
      LW:          bad = (b != 2'b00);
      LOP_ILLEGAL: bad = 1'b1;
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_writeback_unit_if.sv
// Request, data-bus and register-file write signals of the load unit.
// master = the load unit, slave = execute stage / memory / register file.
interface load_writeback_unit_if;
  import cpu_types_pkg::*;

  logic        start;
  load_op_t    load_op;
  logic [31:0] address;
  logic [4:0]  rt_index;
  logic [31:0] rt_old;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        busy;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        done;
  logic        addr_error;

  modport master (
    input  start, load_op, address, rt_index, rt_old,
    input  mem_waitrequest, mem_readdata,
    output mem_address, mem_read,
    output busy, write_enable, write_reg, write_data, done, addr_error
  );

  modport slave (
    output start, load_op, address, rt_index, rt_old,
    output mem_waitrequest, mem_readdata,
    input  mem_address, mem_read,
    input  busy, write_enable, write_reg, write_data, done, addr_error
  );

endinterface

// File: rtl/load_extract.sv
// Combinational byte selection / extension / merge of a little-endian
// memory word into the value written back to rt.
module load_extract
  import cpu_types_pkg::*;
(
  input  load_op_t    op,
  input  logic [1:0]  b,
  input  logic [31:0] word,
  input  logic [31:0] rt_old,
  output logic [31:0] data
);

  logic [31:0] byte_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  lwl_shift;
  logic [4:0]  lwr_shift;

  assign byte_word = word >> {b, 3'b000};
  assign sel_byte  = byte_word[7:0];
  assign sel_half  = b[1] ? word[31:16] : word[15:0];
  // 8*(3-b) equals {~b,3'b000} for a two-bit b
  assign lwl_shift = {~b, 3'b000};
  assign lwr_shift = {b, 3'b000};

  always_comb begin
    data = 32'h0;
    case (op)
      LB:      data = {{24{sel_byte[7]}}, sel_byte};
      LBU:     data = {24'h0, sel_byte};
      LH:      data = {{16{sel_half[15]}}, sel_half};
      LHU:     data = {16'h0, sel_half};
      LW:      data = word;
      LWL:     data = (word << lwl_shift) | (rt_old & ((32'h1 << lwl_shift) - 32'h1));
      LWR:     data = (word >> lwr_shift) | (rt_old & ~(32'hFFFF_FFFF >> lwr_shift));
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_writeback_unit.sv
// Load path: one aligned bus read per request, then a single-cycle
// register-file write of the extracted / merged value.
module load_writeback_unit
  import cpu_types_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  load_writeback_unit_if.master  bus
);

  lwb_state_t  state_reg, state_next;
  load_op_t    op_reg;
  logic [31:0] addr_reg;
  logic [4:0]  rt_reg;
  logic [31:0] rt_old_reg;
  logic [31:0] word_reg;
  logic [31:0] extract_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request is latched so the bus address and merge operand stay stable
  // even if the execute stage moves on.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg     <= LB;
      addr_reg   <= 32'h0;
      rt_reg     <= 5'd0;
      rt_old_reg <= 32'h0;
      word_reg   <= 32'h0;
    end else begin
      if (state_reg == IDLE && bus.start) begin
        op_reg     <= bus.load_op;
        addr_reg   <= bus.address;
        rt_reg     <= bus.rt_index;
        rt_old_reg <= bus.rt_old;
      end
      if (state_reg == READ && !bus.mem_waitrequest) begin
        word_reg <= bus.mem_readdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = bad_request(bus.load_op, bus.address[1:0]) ? ERROR : READ;
        end
      end
      READ:      if (!bus.mem_waitrequest) state_next = WRITEBACK;
      WRITEBACK: state_next = IDLE;
      ERROR:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  load_extract u_extract (
    .op     (op_reg),
    .b      (addr_reg[1:0]),
    .word   (word_reg),
    .rt_old (rt_old_reg),
    .data   (extract_data)
  );

  always_comb begin
    bus.mem_address  = 32'h0;
    bus.mem_read     = 1'b0;
    bus.busy         = (state_reg != IDLE);
    bus.write_enable = 1'b0;
    bus.write_reg    = 5'd0;
    bus.write_data   = 32'h0;
    bus.done         = 1'b0;
    bus.addr_error   = 1'b0;
    case (state_reg)
      READ: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = {addr_reg[31:2], 2'b00};
      end
      WRITEBACK: begin
        bus.write_enable = (rt_reg != 5'd0);
        bus.write_reg    = rt_reg;
        bus.write_data   = extract_data;
        bus.done         = 1'b1;
      end
      ERROR: begin
        bus.addr_error = 1'b1;
        bus.done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
